// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-register busy scoreboard, write bypass and bulk clear
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_dst,
  output logic                  iss_ready,
  output logic                  stall,
  input  logic                  clr_req,
  output logic                  clr_active,
  output logic                  clr_done
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   clr_idx, idx_next;
  logic                done_q, done_next;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [NREGS-1:0]    busy;
  logic                idle;

  assign idle       = (state == S_IDLE);
  assign clr_active = (state == S_CLEAR);
  assign clr_done   = done_q;

  // Forwarding is suppressed during a clear so reads always reflect storage.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = (BYPASS != 0) && idle && wr_en && (wr_addr == a) && (a != '0);
    assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : ((a == '0) ? '0 : regs[a]);
    assign rd_busy[k] = busy[a] && !hit;
  end

  assign stall     = (|rd_busy) || clr_active;
  assign iss_ready = idle && ((iss_dst == '0) || !busy[iss_dst] ||
                              (wr_en && (wr_addr == iss_dst)));

  always_comb begin
    state_next = state;
    idx_next   = clr_idx;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_req) begin
          state_next = S_CLEAR;
          idx_next   = ADDR_W'(1);
        end
      end
      S_CLEAR: begin
        idx_next = clr_idx + ADDR_W'(1);
        if (clr_idx == LAST_IDX) begin
          state_next = S_IDLE;
          idx_next   = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy    <= '0;
      clr_idx <= '0;
      state   <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      clr_idx <= idx_next;
      done_q  <= done_next;
      if (clr_active) begin
        regs[clr_idx] <= '0;
        busy[clr_idx] <= 1'b0;
      end else begin
        if (wr_en && (wr_addr != '0)) begin
          regs[wr_addr] <= wr_data;
          busy[wr_addr] <= 1'b0;
        end
        // Issued later in program order than the writeback, so the claim wins.
        if (iss_valid && iss_ready && (iss_dst != '0)) busy[iss_dst] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed bench for regfile_sb against a behavioural model
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data1, rd_data0;
  logic [NP-1:0]    rd_busy1, rd_busy0;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_dst;
  logic            iss_ready1, iss_ready0, stall1, stall0;
  logic            clr_req;
  logic            clr_active1, clr_active0, clr_done1, clr_done0;

  int n_checks = 0;
  int n_pass = 0;

  regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NP), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .iss_ready(iss_ready1), .stall(stall1), .clr_req(clr_req),
    .clr_active(clr_active1), .clr_done(clr_done1)
  );

  regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NP), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_dst(iss_dst), .iss_ready(iss_ready0), .stall(stall0), .clr_req(clr_req),
    .clr_active(clr_active0), .clr_done(clr_done0)
  );

  // Behavioural model: architectural contents, pending-write flags, clear progress.
  logic [DW-1:0] m_mem [NR];
  bit            m_busy [NR];
  bit            m_clear;
  int            m_idx;
  bit            m_done;

  function automatic logic [DW-1:0] exp_data(int k, bit byp);
    int a;
    a = int'(rd_addr[k*AW +: AW]);
    if (a == 0) return '0;
    if (byp && !m_clear && wr_en && int'(wr_addr) == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(int k, bit byp);
    int a;
    a = int'(rd_addr[k*AW +: AW]);
    if (byp && !m_clear && wr_en && a != 0 && int'(wr_addr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit exp_ready();
    if (m_clear) return 1'b0;
    return (iss_dst == 0) || !m_busy[iss_dst] || (wr_en && wr_addr == iss_dst);
  endfunction

  task automatic model_update();
    bit rdy;
    rdy = exp_ready();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
      m_clear = 1'b0; m_idx = 0; m_done = 1'b0;
    end else if (m_clear) begin
      m_mem[m_idx] = '0;
      m_busy[m_idx] = 1'b0;
      m_done = (m_idx == NR - 1);
      if (m_idx == NR - 1) m_clear = 1'b0;
      m_idx++;
    end else begin
      m_done = 1'b0;
      if (wr_en && wr_addr != 0) begin m_mem[wr_addr] = wr_data; m_busy[wr_addr] = 1'b0; end
      if (iss_valid && rdy && iss_dst != 0) m_busy[iss_dst] = 1'b1;
      if (clr_req) begin m_clear = 1'b1; m_idx = 1; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_dst = '0; clr_req = 1'b0; rd_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle(); tick(); tick();
    rst = 1'b0; @(negedge clk);
    n_checks++; if (rd_data1 !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data1); else n_pass++;
    n_checks++; if (rd_busy1 !== '0) $display("FAIL reset_rd_busy: got %b want 0", rd_busy1); else n_pass++;
    n_checks++; if (stall1 !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall1); else n_pass++;
    n_checks++; if (iss_ready1 !== 1'b1) $display("FAIL reset_iss_ready: got %b want 1", iss_ready1); else n_pass++;
    n_checks++; if ({clr_active1, clr_done1} !== 2'b00) $display("FAIL reset_clr: got %b want 00", {clr_active1, clr_done1}); else n_pass++;
    tick();
  endtask

  task automatic test_write_read();
    drive_idle(); wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; tick();
    drive_idle(); rd_addr = {5'd0, 5'd5}; @(negedge clk);
    n_checks++; if (rd_data1[31:0] !== 32'hDEADBEEF) $display("FAIL wr_rd_r5_byp1: got %h want deadbeef", rd_data1[31:0]); else n_pass++;
    n_checks++; if (rd_data0[31:0] !== 32'hDEADBEEF) $display("FAIL wr_rd_r5_byp0: got %h want deadbeef", rd_data0[31:0]); else n_pass++;
    tick();
    drive_idle(); wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; @(negedge clk);
    n_checks++; if (rd_data1 !== '0) $display("FAIL r0_no_bypass: got %h want 0", rd_data1); else n_pass++;
    tick();
    drive_idle(); @(negedge clk);
    n_checks++; if (rd_data1[31:0] !== 32'h0 || rd_data0[31:0] !== 32'h0) $display("FAIL r0_reads_zero: got %h/%h want 0", rd_data1[31:0], rd_data0[31:0]); else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    drive_idle(); wr_en = 1'b1; wr_addr = 7; wr_data = 32'h0BAD0007; tick();
    drive_idle(); wr_en = 1'b1; wr_addr = 7; wr_data = 32'h12345678; rd_addr = {5'd7, 5'd2}; @(negedge clk);
    n_checks++; if (rd_data1[63:32] !== 32'h12345678) $display("FAIL bypass_data: got %h want 12345678", rd_data1[63:32]); else n_pass++;
    n_checks++; if (rd_busy1[1] !== 1'b0) $display("FAIL bypass_busy: got %b want 0", rd_busy1[1]); else n_pass++;
    n_checks++; if (rd_data0[63:32] !== 32'h0BAD0007) $display("FAIL nobypass_old: got %h want 0bad0007", rd_data0[63:32]); else n_pass++;
    tick();
    drive_idle(); rd_addr = {5'd7, 5'd0}; @(negedge clk);
    n_checks++; if (rd_data0[63:32] !== 32'h12345678) $display("FAIL nobypass_after: got %h want 12345678", rd_data0[63:32]); else n_pass++;
    tick();
  endtask

  task automatic test_scoreboard();
    drive_idle(); iss_valid = 1'b1; iss_dst = 3; @(negedge clk);
    n_checks++; if (iss_ready1 !== 1'b1) $display("FAIL claim_ready: got %b want 1", iss_ready1); else n_pass++;
    tick();
    for (int c = 0; c < 3; c++) begin
      drive_idle(); rd_addr = {5'd0, 5'd3}; iss_valid = 1'b1; iss_dst = 3; @(negedge clk);
      n_checks++; if (rd_busy1[0] !== 1'b1 || stall1 !== 1'b1) $display("FAIL sb_busy: got busy=%b stall=%b want 1/1", rd_busy1[0], stall1); else n_pass++;
      n_checks++; if (iss_ready1 !== 1'b0 || iss_ready0 !== 1'b0) $display("FAIL sb_waw: got %b/%b want 0/0", iss_ready1, iss_ready0); else n_pass++;
      tick();
    end
    drive_idle(); rd_addr = {5'd0, 5'd3}; wr_en = 1'b1; wr_addr = 3; wr_data = 32'hC0DE0003; @(negedge clk);
    n_checks++; if (rd_busy1[0] !== 1'b0 || stall1 !== 1'b0) $display("FAIL sb_wb_byp: got busy=%b stall=%b want 0/0", rd_busy1[0], stall1); else n_pass++;
    n_checks++; if (rd_busy0[0] !== 1'b1 || stall0 !== 1'b1) $display("FAIL sb_wb_nobyp: got busy=%b stall=%b want 1/1", rd_busy0[0], stall0); else n_pass++;
    tick();
    drive_idle(); rd_addr = {5'd0, 5'd3}; @(negedge clk);
    n_checks++; if (rd_busy0[0] !== 1'b0 || stall0 !== 1'b0) $display("FAIL sb_released: got busy=%b stall=%b want 0/0", rd_busy0[0], stall0); else n_pass++;
    n_checks++; if (rd_data0[31:0] !== 32'hC0DE0003) $display("FAIL sb_data: got %h want c0de0003", rd_data0[31:0]); else n_pass++;
    tick();
  endtask

  task automatic test_write_claim();
    drive_idle(); wr_en = 1'b1; wr_addr = 3; wr_data = 32'hA5A5A5A5; iss_valid = 1'b1; iss_dst = 3; @(negedge clk);
    n_checks++; if (iss_ready1 !== 1'b1) $display("FAIL wc_ready: got %b want 1", iss_ready1); else n_pass++;
    tick();
    drive_idle(); rd_addr = {5'd0, 5'd3}; @(negedge clk);
    n_checks++; if (rd_busy1[0] !== 1'b1 || rd_busy0[0] !== 1'b1) $display("FAIL wc_busy: got %b/%b want 1/1", rd_busy1[0], rd_busy0[0]); else n_pass++;
    n_checks++; if (rd_data1[31:0] !== 32'hA5A5A5A5) $display("FAIL wc_data: got %h want a5a5a5a5", rd_data1[31:0]); else n_pass++;
    tick();
    drive_idle(); wr_en = 1'b1; wr_addr = 3; wr_data = 32'h0; tick();
  endtask

  task automatic test_random();
    logic [NP*DW-1:0] e1, e0;
    logic [NP-1:0]    b1, b0;
    for (int c = 0; c < 300; c++) begin
      drive_idle();
      wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(0, 7)); wr_data = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_dst = AW'($urandom_range(0, 7));
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      @(negedge clk);
      e1 = {exp_data(1, 1'b1), exp_data(0, 1'b1)};
      e0 = {exp_data(1, 1'b0), exp_data(0, 1'b0)};
      b1 = {exp_busy(1, 1'b1), exp_busy(0, 1'b1)};
      b0 = {exp_busy(1, 1'b0), exp_busy(0, 1'b0)};
      n_checks++; if (rd_data1 !== e1) $display("FAIL rnd_data1 c%0d: got %h want %h", c, rd_data1, e1); else n_pass++;
      n_checks++; if (rd_data0 !== e0) $display("FAIL rnd_data0 c%0d: got %h want %h", c, rd_data0, e0); else n_pass++;
      n_checks++; if (rd_busy1 !== b1 || stall1 !== (|b1)) $display("FAIL rnd_busy1 c%0d: got %b/%b want %b", c, rd_busy1, stall1, b1); else n_pass++;
      n_checks++; if (rd_busy0 !== b0 || stall0 !== (|b0)) $display("FAIL rnd_busy0 c%0d: got %b/%b want %b", c, rd_busy0, stall0, b0); else n_pass++;
      n_checks++; if (iss_ready1 !== exp_ready() || iss_ready0 !== exp_ready()) $display("FAIL rnd_ready c%0d: got %b/%b want %b", c, iss_ready1, iss_ready0, exp_ready()); else n_pass++;
      tick();
    end
    drive_idle();
  endtask

  task automatic fill_regs();
    for (int a = 1; a < NR; a++) begin
      drive_idle(); wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h5000_0000 + a; tick();
    end
    drive_idle(); iss_valid = 1'b1; iss_dst = 9; tick();
  endtask

  task automatic test_clear();
    int act1, act0, done1, done0, bad;
    bit prev_active;
    fill_regs();
    drive_idle(); clr_req = 1'b1; tick();
    act1 = 0; act0 = 0; done1 = 0; done0 = 0; bad = 0; prev_active = 1'b1;
    for (int c = 0; c < 60; c++) begin
      drive_idle();
      if (m_clear) begin
        wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(1, 31)); wr_data = $urandom | 32'h1;
        iss_valid = 1'($urandom_range(0, 1)); iss_dst = AW'($urandom_range(1, 31));
        clr_req = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (clr_active1) act1++;
      if (clr_active0) act0++;
      if (clr_done0) done0++;
      if (clr_done1) begin
        done1++;
        if (!prev_active || clr_active1) bad++;
      end
      if (clr_active1 && (iss_ready1 !== 1'b0 || stall1 !== 1'b1)) bad++;
      prev_active = clr_active1;
      tick();
    end
    n_checks++; if (act1 !== 31 || act0 !== 31) $display("FAIL clr_cycles: got %0d/%0d want 31", act1, act0); else n_pass++;
    n_checks++; if (done1 !== 1 || done0 !== 1) $display("FAIL clr_done_count: got %0d/%0d want 1", done1, done0); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL clr_control: got %0d bad cycles want 0", bad); else n_pass++;
    for (int a = 0; a < NR; a += 2) begin
      drive_idle(); rd_addr = {AW'(a + 1), AW'(a)}; @(negedge clk);
      n_checks++; if (rd_data1 !== '0 || rd_data0 !== '0 || rd_busy1 !== '0) $display("FAIL clr_reads r%0d: got %h/%h busy %b want 0", a, rd_data1, rd_data0, rd_busy1); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt, seen;
    fill_regs();
    drive_idle(); clr_req = 1'b1; tick();
    drive_idle();
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 10; c++) begin
      @(negedge clk);
      if (clr_active1) cnt++;
      if (cnt == 10) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    n_checks++; if (cnt !== 10) $display("FAIL rmc_reach: got %0d active cycles want 10", cnt); else n_pass++;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      drive_idle(); @(negedge clk);
      if (clr_done1 || clr_done0 || clr_active1 || clr_active0) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) $display("FAIL rmc_no_done: got %0d flagged cycles want 0", seen); else n_pass++;
    for (int a = 0; a < NR; a += 2) begin
      drive_idle(); rd_addr = {AW'(a + 1), AW'(a)}; @(negedge clk);
      n_checks++; if (rd_data1 !== '0 || rd_busy1 !== '0) $display("FAIL rmc_reads r%0d: got %h busy %b want 0", a, rd_data1, rd_busy1); else n_pass++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_write_claim();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count; ADDR_W = clog2(NREGS); register 0 hardwired to zero.
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have input clk, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have input rd_addr, NRD*ADDR_W bits: read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have output rd_data, NRD*DATA_W bits: read data, combinational, packed the same way.
REQ-009 SHALL have output rd_busy, NRD bits: bit k = port k source has a pending write not satisfied this cycle.
REQ-010 SHALL have input wr_en, 1 bit; wr_addr, ADDR_W bits; wr_data, DATA_W bits: writeback port.
REQ-011 SHALL have input iss_valid, 1 bit; iss_dst, ADDR_W bits: an instruction claiming iss_dst as its destination.
REQ-012 SHALL have output iss_ready, 1 bit: the claim is accepted this cycle.
REQ-013 SHALL have output stall, 1 bit: OR of rd_busy.
REQ-014 SHALL have input clr_req, 1 bit; outputs clr_active and clr_done, 1 bit each: bulk-clear control.

Function
REQ-015 SHALL keep a busy bit per register; register 0 SHALL never be busy, never be written, and always read as 0.
REQ-016 SHALL make port k return wr_data when BYPASS=1, wr_en=1, wr_addr==rd_addr[k] and the address is nonzero; otherwise it SHALL return the stored value.
REQ-017 SHALL set rd_busy[k] when busy[rd_addr[k]]=1, unless BYPASS=1 and the bypass condition of REQ-016 holds for that port.
REQ-018 SHALL, on wr_en=1 with nonzero wr_addr in IDLE, write wr_data at the next edge and clear busy[wr_addr]; a write to a non-busy register SHALL still be performed.
REQ-019 SHALL drive iss_ready=1 when the FSM is IDLE and either iss_dst==0 or busy[iss_dst]=0 or (wr_en=1 and wr_addr==iss_dst); otherwise iss_ready=0 (WAW stall).
REQ-020 SHALL, on iss_valid=1 and iss_ready=1 with nonzero iss_dst, set busy[iss_dst] at the next edge; when a write and a claim target the same register in one cycle, the claim SHALL win and busy SHALL remain 1.
REQ-021 SHALL implement FSM IDLE/CLEAR: IDLE with clr_req=1 goes to CLEAR with index=1; CLEAR zeroes register[index] and busy[index], one per cycle, then increments index; after index NREGS-1 it returns to IDLE.
REQ-022 SHALL pulse clr_done for exactly one cycle, in the cycle the FSM is back in IDLE; clear takes NREGS-1 cycles.
REQ-023 SHALL, while in CLEAR, hold clr_active=1, iss_ready=0 and stall=1, ignore wr_en and ignore clr_req.
REQ-024 SHALL, in CLEAR, read every port from storage and SHALL NOT bypass.
REQ-025 SHALL, when wr_addr or iss_dst equals 0, ignore the operation without error.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, zero all registers, all busy bits and the clear index, and put the FSM in IDLE, taking priority over every other input.
REQ-027 SHALL, one cycle after reset, drive rd_data=0, rd_busy=0, stall=0, iss_ready=1 (given iss_dst idle), clr_active=0 and clr_done=0.
REQ-028 SHALL let rst asserted during CLEAR abort the sequence with no clr_done pulse.

Verification
REQ-029 SHALL cover: write 0xDEADBEEF to r5, next cycle read r5 on port 0 -> rd_data=0xDEADBEEF; write to r0 -> r0 still reads 0.
REQ-030 SHALL cover bypass: BYPASS=1, wr_en with r7=0x12345678 while port 1 reads r7 -> same-cycle 0x12345678 and rd_busy[1]=0; with BYPASS=0 the old value is returned.
REQ-031 SHALL cover scoreboard: claim r3, then read r3 -> rd_busy=1 and stall=1 until write r3; a second claim of r3 -> iss_ready=0.
REQ-032 SHALL cover a simultaneous write and claim of r3 -> busy[r3]=1 afterwards and data updated.
REQ-033 SHALL cover bulk clear: NREGS=32 with nonzero registers, pulse clr_req -> clr_active for 31 cycles, clr_done pulses once, all reads 0 afterwards, and wr_en during the clear is ignored.
REQ-034 SHALL cover reset mid-clear: rst at clear cycle 10 -> IDLE, all registers 0, no clr_done pulse.
